instr_fetch_sequencer: RTL and testbench

- Parametrised program sequencer for the matrix processor: program counter, instruction store and run-control FSM in one block.
- Replaces the fixed-width PC and ad hoc start/done enable with a single-clock FSM.
- Adds a program load port, stall, jump-target range checking, overflow fault and a run-cycle counter.
- Feeds the instruction decoder and takes its jump and done outputs back.

---
 rtl/instr_fetch_sequencer.sv | 122 ++++++++++++
 tb/tb_instr_fetch_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_sequencer.sv
// Program sequencer: program counter, instruction store and IDLE/RUN/HALT run control.
// Feeds the decoder with mem[pc] and reacts to its jump/done/stall feedback.
module instr_fetch_sequencer #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               St,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               stall,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               done,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic               busy,
  output logic               halted,
  output logic               err,
  output logic [CNT_W-1:0]   cycle_cnt
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Address limits held one bit wider than the PC so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DepthA = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastA  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_we;
  logic [INSTR_W-1:0]  mem [DEPTH];

  logic load_ok, start_ok, jump_ok;
  assign load_ok  = ({1'b0, load_addr}  < DepthA);
  assign start_ok = ({1'b0, start_addr} < DepthA);
  assign jump_ok  = ({1'b0, jump_addr}  < DepthA);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    case (state_q)
      StIdle: begin
        mem_we = load_en && load_ok;
        if (St) begin
          cnt_d = '0;
          if (start_ok) begin
            state_d = StRun;
            pc_d    = start_addr;
            err_d   = 1'b0;
          end else begin
            state_d = StHalt;
            err_d   = 1'b1;
          end
        end
      end
      StRun: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (done) begin
          state_d = StHalt;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (jump) begin
          if (jump_ok) begin
            pc_d = jump_addr;
          end else begin
            state_d = StHalt;
            err_d   = 1'b1;
          end
        end else if (pc_q == LastA) begin
          // Running off the end of the store is a fault, never a wrap.
          state_d = StHalt;
          err_d   = 1'b1;
        end else begin
          pc_d = pc_q + ADDR_W'(1);
        end
      end
      StHalt: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      pc_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Store is deliberately not reset; RST only suppresses a coincident write.
  always_ff @(posedge CLK) begin
    if (mem_we && !RST) mem[load_addr[IdxW-1:0]] <= load_data;
  end

  assign pc          = pc_q;
  assign instr_valid = (state_q == StRun);
  assign instruction = instr_valid ? mem[pc_q[IdxW-1:0]] : '0;
  assign busy        = (state_q == StRun) || (state_q == StHalt);
  assign halted      = (state_q == StHalt);
  assign err         = err_q;
  assign cycle_cnt   = cnt_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Self-checking bench for instr_fetch_sequencer with DEPTH=16, ADDR_W=8.
// Expected instruction words go through a scoreboard queue.
module tb_instr_fetch_sequencer;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned CNT_W   = 16;

  logic               CLK = 1'b0;
  logic               RST, St, load_en, stall, jump, done;
  logic [ADDR_W-1:0]  start_addr, load_addr, jump_addr;
  logic [INSTR_W-1:0] load_data;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid, busy, halted, err;
  logic [CNT_W-1:0]   cycle_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [INSTR_W-1:0] exp_q[$];
  logic [INSTR_W-1:0] exp_w;

  always #5 CLK = ~CLK;

  instr_fetch_sequencer #(
    .INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .St(St), .start_addr(start_addr),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .stall(stall), .jump(jump), .jump_addr(jump_addr), .done(done),
    .pc(pc), .instruction(instruction), .instr_valid(instr_valid),
    .busy(busy), .halted(halted), .err(err), .cycle_cnt(cycle_cnt)
  );

  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
    @(negedge CLK);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge CLK);
    #1 load_en = 1'b0;
  endtask

  // Returns at the negedge of the first cycle after the start was sampled.
  task automatic start_run(input logic [ADDR_W-1:0] a);
    @(negedge CLK);
    St = 1'b1; start_addr = a;
    @(negedge CLK);
    St = 1'b0;
  endtask

  task automatic sb_compare(input string name);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL %s scoreboard empty, got %0h", name, instruction);
    end else begin
      exp_w = exp_q.pop_front();
      if (instruction !== exp_w) begin
        n_fail++; $display("FAIL %s instruction got %0h want %0h", name, instruction, exp_w);
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    n_checks++; if (pc !== 8'd0) begin n_fail++; $display("FAIL rst_pc got %0d want 0", pc); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", err); end
    n_checks++;
    if (cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", cycle_cnt); end
    n_checks++;
    if ({busy, halted, instr_valid} !== 3'b000) begin
      n_fail++; $display("FAIL rst_flags got %b want 000", {busy, halted, instr_valid});
    end
    n_checks++;
    if (instruction !== 32'd0) begin n_fail++; $display("FAIL rst_instr got %0h want 0", instruction); end
  endtask

  task automatic test_linear_run;
    load_word(8'd0, 32'h11);
    load_word(8'd1, 32'h22);
    load_word(8'd2, 32'h33);
    load_word(8'd3, 32'h44);
    load_word(8'd16, 32'hDEAD);  // out of range: must not alias onto mem[0]
    exp_q.push_back(32'h11); exp_q.push_back(32'h22);
    exp_q.push_back(32'h33); exp_q.push_back(32'h44);
    start_run(8'd0);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL lin_valid[%0d] got 0 want 1", k); end
      n_checks++;
      if (pc !== 8'(k)) begin n_fail++; $display("FAIL lin_pc[%0d] got %0d want %0d", k, pc, k); end
      sb_compare("lin_instr");
      if (k == 3) done = 1'b1;
      @(negedge CLK);
    end
    done = 1'b0;
    n_checks++;
    if ({halted, busy, instr_valid} !== 3'b110) begin
      n_fail++; $display("FAIL lin_halt got %b want 110", {halted, busy, instr_valid});
    end
    n_checks++; if (pc !== 8'd3) begin n_fail++; $display("FAIL lin_halt_pc got %0d want 3", pc); end
    @(negedge CLK);
    n_checks++;
    if ({halted, busy} !== 2'b00) begin n_fail++; $display("FAIL lin_idle got %b want 00", {halted, busy}); end
    n_checks++; if (pc !== 8'd3) begin n_fail++; $display("FAIL lin_idle_pc got %0d want 3", pc); end
    n_checks++;
    if (cycle_cnt !== 16'd4) begin n_fail++; $display("FAIL lin_cnt got %0d want 4", cycle_cnt); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL lin_err got %b want 0", err); end
  endtask

  task automatic test_stall_jump;
    load_word(8'd7, 32'h77);
    exp_q.push_back(32'h33); exp_q.push_back(32'h77);
    start_run(8'd2);
    sb_compare("sj_first");
    stall = 1'b1; jump = 1'b1; jump_addr = 8'd7;
    for (int k = 1; k <= 2; k++) begin
      @(negedge CLK);
      n_checks++; if (pc !== 8'd2) begin n_fail++; $display("FAIL sj_hold_pc got %0d want 2", pc); end
      n_checks++;
      if (cycle_cnt !== 16'(k)) begin
        n_fail++; $display("FAIL sj_cnt got %0d want %0d", cycle_cnt, k);
      end
    end
    stall = 1'b0;
    @(negedge CLK);
    jump = 1'b0;
    n_checks++; if (pc !== 8'd7) begin n_fail++; $display("FAIL sj_jump_pc got %0d want 7", pc); end
    n_checks++;
    if (cycle_cnt !== 16'd3) begin n_fail++; $display("FAIL sj_cnt3 got %0d want 3", cycle_cnt); end
    sb_compare("sj_target");
    done = 1'b1;
    @(negedge CLK);
    done = 1'b0;
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL sj_halt got 0 want 1"); end
    @(negedge CLK);
  endtask

  task automatic test_overflow;
    load_word(8'd14, 32'hE0);
    load_word(8'd15, 32'hF0);
    exp_q.push_back(32'hE0); exp_q.push_back(32'hF0);
    start_run(8'd14);
    n_checks++; if (pc !== 8'd14) begin n_fail++; $display("FAIL ov_pc0 got %0d want 14", pc); end
    sb_compare("ov_w14");
    @(negedge CLK);
    n_checks++; if (pc !== 8'd15) begin n_fail++; $display("FAIL ov_pc1 got %0d want 15", pc); end
    sb_compare("ov_w15");
    @(negedge CLK);
    n_checks++;
    if ({halted, err, instr_valid} !== 3'b110) begin
      n_fail++; $display("FAIL ov_halt got %b want 110", {halted, err, instr_valid});
    end
    n_checks++; if (pc !== 8'd15) begin n_fail++; $display("FAIL ov_pc_hold got %0d want 15", pc); end
    @(negedge CLK);
    n_checks++;
    if ({busy, err} !== 2'b01) begin n_fail++; $display("FAIL ov_idle got %b want 01", {busy, err}); end
    n_checks++; if (pc !== 8'd15) begin n_fail++; $display("FAIL ov_idle_pc got %0d want 15", pc); end
  endtask

  task automatic test_illegal_jump;
    start_run(8'd0);
    jump = 1'b1; jump_addr = 8'd20;
    @(negedge CLK);
    jump = 1'b0;
    n_checks++;
    if ({halted, err} !== 2'b11) begin n_fail++; $display("FAIL ij_halt got %b want 11", {halted, err}); end
    n_checks++; if (pc !== 8'd0) begin n_fail++; $display("FAIL ij_pc got %0d want 0", pc); end
    @(negedge CLK);
  endtask

  task automatic test_start_clears_err;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ce_pre_err got %b want 1", err); end
    start_run(8'd0);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ce_err got %b want 0", err); end
    n_checks++;
    if (cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL ce_cnt got %0d want 0", cycle_cnt); end
    n_checks++;
    if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL ce_valid got %b want 1", instr_valid); end
    done = 1'b1;
    @(negedge CLK);
    done = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_bad_start;
    start_run(8'd16);
    n_checks++;
    if ({halted, err, instr_valid} !== 3'b110) begin
      n_fail++; $display("FAIL bs_halt got %b want 110", {halted, err, instr_valid});
    end
    @(negedge CLK);
    n_checks++;
    if ({busy, err} !== 2'b01) begin n_fail++; $display("FAIL bs_idle got %b want 01", {busy, err}); end
  endtask

  task automatic test_reset_midrun;
    exp_q.push_back(32'h11); exp_q.push_back(32'h11);
    start_run(8'd0);
    for (int k = 0; k < 5; k++) @(negedge CLK);
    n_checks++; if (pc !== 8'd5) begin n_fail++; $display("FAIL rm_pc5 got %0d want 5", pc); end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    n_checks++;
    if ({busy, halted, err} !== 3'b000) begin
      n_fail++; $display("FAIL rm_flags got %b want 000", {busy, halted, err});
    end
    n_checks++; if (pc !== 8'd0) begin n_fail++; $display("FAIL rm_pc got %0d want 0", pc); end
    n_checks++;
    if (cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL rm_cnt got %0d want 0", cycle_cnt); end
    start_run(8'd0);
    sb_compare("rm_mem_kept");
    load_en = 1'b1; load_addr = 8'd0; load_data = 32'hBAD; St = 1'b1; start_addr = 8'd7;
    @(negedge CLK);
    load_en = 1'b0; St = 1'b0;
    n_checks++; if (pc !== 8'd1) begin n_fail++; $display("FAIL rm_st_ign got %0d want 1", pc); end
    jump = 1'b1; jump_addr = 8'd0;
    @(negedge CLK);
    jump = 1'b0;
    n_checks++; if (pc !== 8'd0) begin n_fail++; $display("FAIL rm_jpc got %0d want 0", pc); end
    sb_compare("rm_write_ign");
    done = 1'b1;
    @(negedge CLK);
    done = 1'b0;
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL rm_halt got 0 want 1"); end
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; St = 1'b0; load_en = 1'b0; stall = 1'b0; jump = 1'b0; done = 1'b0;
    start_addr = '0; load_addr = '0; load_data = '0; jump_addr = '0;
    test_reset();
    test_linear_run();
    test_stall_jump();
    test_overflow();
    test_illegal_jump();
    test_start_clears_err();
    test_bad_start();
    test_reset_midrun();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover got %0d want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
